// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with read-ahead addressing and latency-matched sync/blank/colour outputs.
// Optional test pattern selected at build time with VGA_TESTPAT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned H_AW     = 10,
  parameter int unsigned V_AW     = 10,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
`ifdef VGA_TESTPAT_EN
  input  logic                   test_en,
`endif
  output logic [H_AW-1:0]        h_addr,
  output logic [V_AW-1:0]        v_addr,
  output logic                   rd_en,
  input  logic [3*COLOR_W-1:0]   vga_data,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   valid,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_END   = V_START + V_ACTIVE;
  localparam int unsigned H_CW    = $clog2(H_TOTAL + 1);
  localparam int unsigned V_CW    = $clog2(V_TOTAL + 1);
  localparam int unsigned PIX_W   = 3 * COLOR_W;
`ifdef VGA_TESTPAT_EN
  localparam int unsigned DW = 6;
  localparam logic [DW-1:0] DLY_RST = {~HS_POL, ~VS_POL, 4'b0000};
`else
  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] DLY_RST = {~HS_POL, ~VS_POL, 2'b00};
`endif

  logic [H_CW-1:0]  h_cnt_q, h_cnt_d;
  logic [V_CW-1:0]  v_cnt_q, v_cnt_d;
  logic             h_act, v_act, first_px;
  logic [DW-1:0]    s0;
  logic [DW-1:0]    dly_out;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             valid_q, valid_d, fs_q, fs_d;
  logic [PIX_W-1:0] color_q, color_d;

  // Raster counters: h wraps every line, v advances on h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + H_CW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_CW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_CW'(V_TOTAL - 1)) ? '0 : v_cnt_q + V_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 0: read address and control bits straight from the counters.
  always_comb begin
    h_act    = (h_cnt_q >= H_CW'(H_START)) && (h_cnt_q < H_CW'(H_END));
    v_act    = (v_cnt_q >= V_CW'(V_START)) && (v_cnt_q < V_CW'(V_END));
    rd_en    = h_act && v_act;
    h_addr   = rd_en ? H_AW'(h_cnt_q - H_CW'(H_START)) : '0;
    v_addr   = rd_en ? V_AW'(v_cnt_q - V_CW'(V_START)) : '0;
    first_px = rd_en && (h_addr == '0) && (v_addr == '0);
`ifdef VGA_TESTPAT_EN
    s0 = {(h_cnt_q < H_CW'(H_SYNC)) ? HS_POL : ~HS_POL,
          (v_cnt_q < V_CW'(V_SYNC)) ? VS_POL : ~VS_POL,
          rd_en, first_px, test_en, h_addr[4] ^ v_addr[4]};
`else
    s0 = {(h_cnt_q < H_CW'(H_SYNC)) ? HS_POL : ~HS_POL,
          (v_cnt_q < V_CW'(V_SYNC)) ? VS_POL : ~VS_POL,
          rd_en, first_px};
`endif
  end

  // Controls wait here while the memory produces the pixel.
  if (RD_LAT == 0) begin : g_nodly
    assign dly_out = s0;
  end else begin : g_dly
    logic [DW-1:0] dly_q [RD_LAT];
    logic [DW-1:0] dly_d [RD_LAT];

    always_comb begin
      dly_d[0] = s0;
      for (int i = 1; i < int'(RD_LAT); i++) dly_d[i] = dly_q[i-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < int'(RD_LAT); i++) dly_q[i] <= DLY_RST;
      end else begin
        for (int i = 0; i < int'(RD_LAT); i++) dly_q[i] <= dly_d[i];
      end
    end

    assign dly_out = dly_q[RD_LAT-1];
  end

  // Output stage; colour is blanked whenever the aligned pixel is not visible.
  always_comb begin
    hsync_d = dly_out[DW-1];
    vsync_d = dly_out[DW-2];
    valid_d = dly_out[DW-3];
    fs_d    = dly_out[DW-4];
    color_d = '0;
    if (dly_out[DW-3]) begin
`ifdef VGA_TESTPAT_EN
      color_d = dly_out[1] ? {PIX_W{dly_out[0]}} : vga_data;
`else
      color_d = vga_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      color_q <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      color_q <= color_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign frame_start = fs_q;
  assign vga_r       = color_q[PIX_W-1 -: COLOR_W];
  assign vga_g       = color_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b       = color_q[COLOR_W-1:0];

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel pipeline that supersedes the fixed 640x480 controller. It produces pixel-memory read addresses RD_LAT cycles ahead of display, so registered or synchronous video memories can be used. It also delays sync, blank and frame markers to line up with the returned pixel data. It sits between the frame-buffer/character-memory block and the board VGA pins.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: horizontal sync width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vertical sync width, in lines
- V_BP, 33: vertical back porch, in lines
- HS_POL, 0: hsync active level
- VS_POL, 0: vsync active level
- H_AW, 10: width of h_addr
- V_AW, 10: width of v_addr
- COLOR_W, 8: bits per colour channel
- RD_LAT, 1: pixel-memory read latency in cycles, legal range 0..4

Ports:
- clk  in  1  pixel clock
- resetn  in  1  asynchronous, active-low reset
- h_addr  out  H_AW  read column; 0 outside the active region
- v_addr  out  V_AW  read row; 0 outside the active region
- rd_en  out  1  address valid, i.e. current counter position is active
- vga_data  in  3*COLOR_W  pixel {R,G,B}, returned RD_LAT cycles after its address
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- valid  out  1  blank_n; high when the pixel is visible
- vga_r, vga_g, vga_b  out  COLOR_W each  colour channels
- frame_start  out  1  one-cycle pulse aligned with the first visible pixel of each frame
- test_en  in  1  test-pattern select; present only when VGA_TESTPAT_EN is defined

## Operation
- Totals:
  - H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP
  - V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP
- h_cnt counts 0..H_TOTAL-1, then wraps to 0.
- v_cnt increments only when h_cnt wraps; it counts 0..V_TOTAL-1, then wraps to 0.
- Region order, both axes: sync, back porch, active, front porch, with sync starting at count 0.
  - h_act = (h_cnt >= H_SYNC+H_BP) && (h_cnt < H_SYNC+H_BP+H_ACTIVE); v_act is defined the same way.
  - Sync is asserted while h_cnt < H_SYNC (or v_cnt < V_SYNC).
- Stage 0 (combinational from the counters):
  - rd_en = h_act && v_act
  - h_addr = h_cnt - (H_SYNC+H_BP) when rd_en, else 0; v_addr is formed the same way.
- Delay line: {hsync, vsync, rd_en, first_pixel} pass through a RD_LAT-deep shift register.
  - first_pixel = (h_addr == 0 && v_addr == 0 && rd_en).
- Output register, one cycle: captures the delayed controls plus vga_data.
  - Colour is forced to 0 when the delayed rd_en is 0.
- Address arithmetic is unsigned and truncated to H_AW/V_AW; a parameter set with H_ACTIVE > 2^H_AW is illegal.
- Reset, asynchronous on resetn low:
  - Counters and the delay line are cleared.
  - hsync = ~HS_POL and vsync = ~VS_POL, with the delay line holding inactive sync levels.
  - valid = 0, colours = 0, frame_start = 0.
- Reset released mid-frame: the generator restarts at h_cnt = v_cnt = 0. No partial line is produced before the first vsync.

## Timing
- Address-to-output latency is RD_LAT+1 cycles.
  - A pixel addressed at cycle t appears on vga_r/g/b and valid at cycle t+RD_LAT+1.
  - hsync, vsync and frame_start carry the same latency as the pixels, so all outputs stay mutually aligned.
- Line period is H_TOTAL cycles; frame period is H_TOTAL*V_TOTAL cycles.
- The first output cycles after reset show inactive sync, valid=0 and colour 0, even though the delay line is not yet primed by real counter values.
- frame_start pulses exactly once per frame. It is high on the same cycle as valid for pixel (0,0).

## Configuration
- VGA_TESTPAT_EN defined:
  - The test_en port exists.
  - When test_en=1, stage-0 colour replaces vga_data: all channels all-ones if h_addr[4]^v_addr[4], else 0.
  - The test colour passes through the same RD_LAT+1 delay, so alignment is unchanged.
  - test_en is sampled per pixel.
- VGA_TESTPAT_EN undefined:
  - No test_en port and no pattern logic.
  - Colour always comes from vga_data.

## Test plan
- Small timing (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, RD_LAT=0), run 2 frames -> hsync period 8 cycles, low for 2; vsync period 48 cycles, low for 8; valid high for 4 of every 8 cycles on 3 lines per frame.
- Same timing, memory model returns {h_addr, v_addr} as the pixel, RD_LAT swept 0..4 -> every valid cycle outputs the pixel for the matching (x,y); first valid pixel of a line is x=0; no pixel is lost or duplicated.
- Hold resetn low for 5 cycles mid-line -> outputs are immediately hsync=1, vsync=1, valid=0, colour 0 (HS_POL=VS_POL=0); after release, the first hsync-low cycle follows RD_LAT+1 cycles later.
- Count frame_start over 3 frames -> exactly 3 single-cycle pulses, each coincident with valid and pixel (0,0).
- With VGA_TESTPAT_EN, H_ACTIVE=64, test_en=1 -> x=16..31 on line 0 output all-ones; x=0..15 output 0; line 16 shows the inverse pattern.
- Drive vga_data all-ones constantly -> colour outputs are 0 on every cycle where valid=0.
